instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential MIPS instruction encoder: the inverse of the opcode-type decode path. It accepts instruction fields plus a format tag (R/I/J) over a valid/ready handshake and packs them into 32-bit instruction words. It rejects illegal format/opcode combinations and buffers the encoded words in a small FIFO. It emits each word with a sequential word address over a second valid/ready handshake. It sits in the program-loader path in front of instruction memory and is the source of program images for the CPU testbenches.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- ADDR_WIDTH, 8: width of the word-address counter.
- BASE_ADDR, 0: word address assigned to the first emitted word after reset.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle this cycle.
- fmt  in  2  00 R-type, 01 I-type, 10 J-type, 11 illegal.
- opcode  in  6  opcode for I/J; ignored for R.
- rs, rt, rd, shamt  in  5 each  register/shift fields.
- funct  in  6  R-type function.
- imm  in  16  I-type immediate.
- target  in  26  J-type target.
- out_valid  out  1  out_instr/out_addr valid.
- out_ready  in  1  sink accepts word.
- out_instr  out  32  encoded word.
- out_addr  out  ADDR_WIDTH  word address of out_instr.
- err  out  1  sticky: an illegal bundle was dropped.

## Operation
- Accept when in_valid && in_ready. Encoding:
  - R: {6'b000000, rs, rt, rd, shamt, funct}. The opcode input is ignored.
  - I: {opcode, rs, rt, imm}. Legal only if opcode ∉ {000000, 000010, 000011}.
  - J: {opcode, target}. Legal only if opcode ∈ {000010, 000011}.
- Illegal bundle (fmt=11, or a failed opcode check):
  - Still consumed through the handshake.
  - Not written to the FIFO; out_addr does not advance.
  - err set at the next edge; cleared only by rst.
- Legal bundle: the encoded word is pushed into the FIFO at the accepting edge.
- FIFO: DEPTH entries, occupancy count 0..DEPTH, wrapping read/write pointers.
  - in_ready = !rst && (count < DEPTH). It depends only on registered state: no combinational path from out_ready.
- Output:
  - out_valid = (count > 0).
  - out_instr = FIFO head.
  - out_addr = address counter.
  - Pop on out_valid && out_ready; the address counter increments by 1 on each pop.
- Address counter wraps at 2^ADDR_WIDTH − 1 → 0. No flag, no stall.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal at any occupancy where both handshakes are individually enabled, including count=DEPTH (pop only; in_ready=0 so no push).
- Simultaneous illegal accept and pop: pop proceeds normally; err sets.
- Reset mid-operation discards all FIFO contents; words already popped are not re-emitted.

## Timing
- While rst is high and at the first edge after rst falls:
  - in_ready=0 while rst is high; 1 after.
  - out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, count=0.
- Latency:
  - A bundle accepted at edge N into an empty FIFO gives out_valid=1 with the word in cycle N+1 (after edge N).
  - No bypass: zero-cycle latency does not occur.
- Throughput: one accept and one emit per cycle sustained.
- out_instr and out_addr hold stable while out_valid && !out_ready.
- in_ready falls in the cycle after the edge that fills the FIFO. It rises in the cycle after the first pop from full.
- err rises in the cycle after the illegal accept.

## Test plan
- Reset then R-type rs=1, rt=2, rd=3, shamt=0, funct=0x20 (add), out_ready=1:
  - out_instr=0x00221820 and out_addr=0 one cycle after accept.
  - err=0.
- I-type opcode=0x08, rs=0, rt=8, imm=0xFFFF, then J-type opcode=0x03, target=0x0100000:
  - 0x2008FFFF at addr 0.
  - 0x0C100000 at addr 1.
- Illegal cases: fmt=11; I-type opcode=0x02; J-type opcode=0x04. Each is consumed.
  - No output word; out_addr stays.
  - err=1 and stays 1 until rst.
- Backpressure: out_ready=0, push DEPTH+2 legal bundles with in_valid held.
  - Exactly DEPTH are accepted; in_ready=0 after.
  - Raise out_ready: words emerge in order at addr 0..DEPTH−1, then the remaining 2 follow.
- Wrap and overlap:
  - ADDR_WIDTH=3, 10 legal words with out_ready=1 and continuous input: addresses 0..7,0,1. One word per cycle, count constant.
  - Assert rst with 3 words queued: out_valid=0 and out_addr=BASE_ADDR the next cycle; nothing emitted.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs R/I/J instruction fields into 32-bit MIPS words,
// drops illegal format/opcode combinations (sticky err), and queues the
// encoded words in a small FIFO that drains with a sequential word address.
module instr_encoder #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            fmt,
    input  logic [5:0]            opcode,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    input  logic [4:0]            shamt,
    input  logic [5:0]            funct,
    input  logic [15:0]           imm,
    input  logic [25:0]           target,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [31:0]           mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  legal, accept, push, pop;
    logic [31:0]           word;

    // Field packing and legality check; the opcode is ignored for R-type.
    always_comb begin
        legal = 1'b0;
        word  = 32'h0;
        case (fmt)
            2'b00: begin
                legal = 1'b1;
                word  = {6'b000000, rs, rt, rd, shamt, funct};
            end
            2'b01: begin
                // Opcodes 0, 2 and 3 belong to the R/J formats.
                legal = !(opcode == 6'd0 || opcode == 6'd2 || opcode == 6'd3);
                word  = {opcode, rs, rt, imm};
            end
            2'b10: begin
                legal = (opcode == 6'd2 || opcode == 6'd3);
                word  = {opcode, target};
            end
            default: begin
                legal = 1'b0;
                word  = 32'h0;
            end
        endcase
    end

    // in_ready only looks at registered occupancy, never at out_ready.
    assign in_ready  = !rst && (count < CW'(DEPTH));
    assign out_valid = !rst && (count != '0);
    assign out_instr = out_valid ? mem[rd_ptr] : 32'h0;
    assign out_addr  = addr;

    assign accept = in_valid && in_ready;
    assign push   = accept && legal;
    assign pop    = out_valid && out_ready;

    // FIFO storage; a push is impossible during reset since in_ready is low.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= word;
    end

    // Pointers, occupancy, address counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            addr   <= ADDR_WIDTH'(BASE_ADDR);
            err    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                addr   <= addr + ADDR_WIDTH'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            if (accept && !legal)
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words are queued at the
// accepting handshake and compared, with their address, when popped.
module tb_instr_encoder;
    localparam int DEPTH = 4;
    localparam int AW    = 3;

    logic          clk = 1'b0, rst = 1'b1;
    logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, err;
    logic [1:0]    fmt = '0;
    logic [5:0]    opcode = '0, funct = '0;
    logic [4:0]    rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [15:0]   imm = '0;
    logic [25:0]   target = '0;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;

    int errors = 0, checks = 0, pops = 0, accepted = 0, cyc_cnt = 0;
    logic [31:0]   exp_q[$];
    logic [AW-1:0] exp_addr = '0;
    logic          exp_err = 1'b0;
    bit            done;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm), .target(target), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [1:0] f, input logic [5:0] op,
        input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] s,
        input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
        case (f)
            2'd0:    return {6'd0, a, b, c, s, fn};
            2'd1:    return {op, a, b, im};
            2'd2:    return {op, tg};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [1:0] f, input logic [5:0] op);
        case (f)
            2'd0:    return 1'b1;
            2'd1:    return !(op == 6'd0 || op == 6'd2 || op == 6'd3);
            2'd2:    return (op == 6'd2 || op == 6'd3);
            default: return 1'b0;
        endcase
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic send(input logic [1:0] f, input logic [5:0] op,
        input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] s,
        input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg,
        input logic lg, input logic [31:0] w);
        int n = 0;
        bit ok = 0;
        fmt = f; opcode = op; rs = a; rt = b; rd = c; shamt = s;
        funct = fn; imm = im; target = tg; in_valid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                accepted++;
                if (lg) exp_q.push_back(w);
            end
            n++;
        end
        if (!ok) chk("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (ok && !lg) exp_err = 1'b1;
    endtask

    task automatic send_m(input logic [1:0] f, input logic [5:0] op,
        input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] s,
        input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
        send(f, op, a, b, c, s, fn, im, tg, is_legal(f, op), enc(f, op, a, b, c, s, fn, im, tg));
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0;
        exp_q.delete(); exp_addr = '0; exp_err = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid_now", out_valid, 0);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: address/err every cycle, head word while valid.
    always @(negedge clk) begin
        if (!rst) begin
            chk("addr", out_addr, exp_addr);
            chk("err", err, exp_err);
            if (out_valid) begin
                if (exp_q.size() == 0) chk("spurious_valid", out_valid, 0);
                else begin
                    chk("instr", out_instr, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        pops++;
                        exp_addr = exp_addr + AW'(1);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int p0, a0, c0;
        logic [4:0] a5;
        do_reset();

        // R-type add, one-cycle latency.
        out_ready = 1'b1;
        send(2'd0, 6'h3f, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1, 32'h00221820);
        @(negedge clk);
        chk("lat_valid", out_valid, 1);
        chk("lat_instr", out_instr, 32'h00221820);
        cyc(2);
        chk("t1_err", err, 0);

        // I-type then J-type from reset.
        do_reset();
        p0 = pops;
        send(2'd1, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0, 1'b1, 32'h2008FFFF);
        send(2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0100000, 1'b1, 32'h0C100000);
        cyc(3);
        chk("t2_pops", pops - p0, 2);

        // Illegal bundles: consumed, dropped, err sticky.
        p0 = pops; a0 = accepted;
        send(2'd3, 6'h08, 5'd1, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1, 26'h1, 1'b0, 32'h0);
        send(2'd1, 6'h02, 5'd1, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1, 26'h1, 1'b0, 32'h0);
        send(2'd2, 6'h04, 5'd1, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1, 26'h1, 1'b0, 32'h0);
        cyc(3);
        chk("ill_consumed", accepted - a0, 3);
        chk("ill_no_pop", pops - p0, 0);
        chk("ill_addr_hold", out_addr, 2);
        chk("ill_err", err, 1);
        cyc(5);
        chk("ill_err_sticky", err, 1);

        // Backpressure: DEPTH+2 bundles, only DEPTH accepted until drain.
        do_reset();
        out_ready = 1'b0; p0 = pops; a0 = accepted;
        fork
            for (int i = 0; i < DEPTH + 2; i++) begin
                a5 = 5'(i);
                send_m(2'd0, 6'h0, a5, a5 + 5'd1, a5 + 5'd2, a5, 6'h20, 16'h0, 26'h0);
            end
            begin
                cyc(10);
                chk("bp_accepted", accepted - a0, DEPTH);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
                out_ready = 1'b1;
            end
        join
        cyc(6);
        chk("bp_pops", pops - p0, DEPTH + 2);
        chk("bp_drained", exp_q.size(), 0);

        // Continuous throughput with address wrap 0..7,0,1.
        do_reset();
        out_ready = 1'b1; p0 = pops; c0 = cyc_cnt;
        for (int i = 0; i < 10; i++)
            send_m(2'd1, 6'h23, 5'($urandom), 5'($urandom), 5'd0, 5'd0, 6'h0, 16'($urandom), 26'h0);
        chk("thru_cycles", cyc_cnt - c0, 10);
        cyc(2);
        chk("thru_pops", pops - p0, 10);
        chk("wrap_addr", out_addr, 2);

        // Reset with words queued discards them.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send_m(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'($urandom));
        do_reset();
        out_ready = 1'b1; p0 = pops;
        cyc(4);
        chk("rst_discard_pops", pops - p0, 0);
        chk("rst_discard_valid", out_valid, 0);

        // Random mix of legal/illegal bundles against random backpressure.
        done = 0;
        fork
            begin
                for (int i = 0; i < 30; i++)
                    send_m(2'($urandom_range(0, 3)), 6'($urandom_range(0, 9)),
                           5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                           6'($urandom), 16'($urandom), 26'($urandom));
                done = 1;
            end
            while (!done) begin
                out_ready = 1'($urandom_range(0, 1));
                cyc(1);
            end
        join
        out_ready = 1'b1;
        cyc(10);
        chk("rand_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
